// File: rtl/vga_pkg.sv
// Shared encodings for the VGA timing/pattern generator: pattern modes and bar colours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_GRID    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t BAR_WHITE   = 16'hFFFF;
    localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
    localparam rgb565_t BAR_CYAN    = 16'h07FF;
    localparam rgb565_t BAR_GREEN   = 16'h07E0;
    localparam rgb565_t BAR_MAGENTA = 16'hF81F;
    localparam rgb565_t BAR_RED     = 16'hF800;
    localparam rgb565_t BAR_BLUE    = 16'h001F;
    localparam rgb565_t BAR_BLACK   = 16'h0000;

    localparam int NUM_BARS = 8;

    // Bar index 0..7 maps left to right; anything past the last bar is black.
    function automatic rgb565_t bar_color(input logic [3:0] idx);
        case (idx)
            4'd0:    return BAR_WHITE;
            4'd1:    return BAR_YELLOW;
            4'd2:    return BAR_CYAN;
            4'd3:    return BAR_GREEN;
            4'd4:    return BAR_MAGENTA;
            4'd5:    return BAR_RED;
            4'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters with combinational sync and data-enable decode.
// Latency: decode outputs reflect the current counter state (0 cycles).
// Backpressure: none; free-running at the pixel clock.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = 800,
    parameter int   H_FP      = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BP      = 88,
    parameter int   V_ACTIVE  = 600,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BP      = 23,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1,
    parameter int   ADDR_W    = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [ADDR_W-1:0] h_cnt_o,
    output logic [ADDR_W-1:0] v_cnt_o,
    output logic              line_end_o,
    output logic              origin_o,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int H_SYNC_HI = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int V_SYNC_HI = V_ACTIVE + V_FP + V_SYNC;

    logic [ADDR_W-1:0] h_cnt_q, h_cnt_d;
    logic [ADDR_W-1:0] v_cnt_q, v_cnt_d;
    logic              h_end, v_end;
    logic              h_in_sync, v_in_sync;

    // Next raster position: h wraps each line, v steps only on the h wrap.
    always_comb begin
        h_end   = (h_cnt_q == ADDR_W'(H_TOTAL - 1));
        v_end   = (v_cnt_q == ADDR_W'(V_TOTAL - 1));
        h_cnt_d = h_end ? '0 : h_cnt_q + ADDR_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_end) begin
            v_cnt_d = v_end ? '0 : v_cnt_q + ADDR_W'(1);
        end
    end

    // Counter state register; reset parks the raster at the frame origin.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Region decode; vsync follows v_cnt so it only moves when h_cnt returns to 0.
    always_comb begin
        h_in_sync  = (h_cnt_q >= ADDR_W'(H_SYNC_LO)) && (h_cnt_q < ADDR_W'(H_SYNC_HI));
        v_in_sync  = (v_cnt_q >= ADDR_W'(V_SYNC_LO)) && (v_cnt_q < ADDR_W'(V_SYNC_HI));
        hsync_o    = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
        vsync_o    = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
        de_o       = (h_cnt_q < ADDR_W'(H_ACTIVE)) && (v_cnt_q < ADDR_W'(V_ACTIVE));
        line_end_o = h_end;
        origin_o   = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    assign h_cnt_o = h_cnt_q;
    assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// VGA raster timing plus test-pattern pixel generator (solid, bars, grid, checker).
// Latency: 2 clocks from counter state to every output pin, all outputs aligned.
// Backpressure: none; mode/colour are captured once per frame at the raster origin.
module vga_timing_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = 800,
    parameter int   H_FP      = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BP      = 88,
    parameter int   V_ACTIVE  = 600,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BP      = 23,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1,
    parameter int   ADDR_W    = 12,
    parameter int   GRID_LOG2 = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [15:0]       fg_color,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [ADDR_W-1:0] x_addr,
    output logic [ADDR_W-1:0] y_addr,
    output logic [4:0]        red,
    output logic [5:0]        green,
    output logic [4:0]        blue,
    output logic              frame_start
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;

    logic [ADDR_W-1:0] h_cnt, v_cnt;
    logic              line_end, origin;
    logic              t_de, t_hsync, t_vsync;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HSYNC_POL(HSYNC_POL),
        .VSYNC_POL(VSYNC_POL),
        .ADDR_W   (ADDR_W)
    ) u_timing (
        .clk_i     (clk),
        .rst_i     (rst),
        .h_cnt_o   (h_cnt),
        .v_cnt_o   (v_cnt),
        .line_end_o(line_end),
        .origin_o  (origin),
        .de_o      (t_de),
        .hsync_o   (t_hsync),
        .vsync_o   (t_vsync)
    );

    mode_e             mode_q, mode_d, eff_mode;
    rgb565_t           fg_q, fg_d, eff_fg;
    logic [ADDR_W-1:0] bar_pos_q, bar_pos_d;
    logic [3:0]        bar_idx_q, bar_idx_d;
    rgb565_t           pattern;

    // Stage 1 (decoded from counters) and stage 2 (pins).
    logic              s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_fs_q, s1_fs_d;
    logic [ADDR_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    rgb565_t           s1_rgb_q, s1_rgb_d;
    logic              o_de_q, o_hs_q, o_vs_q, o_fs_q;
    logic [ADDR_W-1:0] o_x_q, o_y_q;
    rgb565_t           o_rgb_q;

    // At the origin the live inputs drive pixel (0,0) directly, so the new frame
    // uses the new settings from its very first pixel.
    always_comb begin
        mode_d   = origin ? mode_e'(mode) : mode_q;
        fg_d     = origin ? fg_color      : fg_q;
        eff_mode = mode_d;
        eff_fg   = fg_d;
    end

    // Bar tracker runs in lockstep with h_cnt so no divider is needed.
    always_comb begin
        bar_pos_d = bar_pos_q;
        bar_idx_d = bar_idx_q;
        if (line_end) begin
            bar_pos_d = '0;
            bar_idx_d = '0;
        end else if (bar_idx_q != 4'(NUM_BARS)) begin
            if (bar_pos_q == ADDR_W'(BAR_W - 1)) begin
                bar_pos_d = '0;
                bar_idx_d = bar_idx_q + 4'd1;
            end else begin
                bar_pos_d = bar_pos_q + ADDR_W'(1);
            end
        end
    end

    // Pattern select for the pixel at the current counter position.
    always_comb begin
        pattern = '0;
        case (eff_mode)
            MODE_SOLID:   pattern = eff_fg;
            MODE_BARS:    pattern = bar_color(bar_idx_q);
            MODE_GRID:    pattern = ((h_cnt[GRID_LOG2-1:0] == '0) || (v_cnt[GRID_LOG2-1:0] == '0))
                                    ? eff_fg : '0;
            MODE_CHECKER: pattern = ((h_cnt[GRID_LOG2] ^ v_cnt[GRID_LOG2]) == 1'b0) ? eff_fg : '0;
            default:      pattern = '0;
        endcase
    end

    // Stage 1 next values: addresses and colour are forced to 0 outside the active area.
    always_comb begin
        s1_de_d  = t_de;
        s1_hs_d  = t_hsync;
        s1_vs_d  = t_vsync;
        s1_fs_d  = origin;
        s1_x_d   = t_de ? h_cnt : '0;
        s1_y_d   = t_de ? v_cnt : '0;
        s1_rgb_d = t_de ? pattern : '0;
    end

    // Frame settings latch and bar tracker state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_SOLID;
            fg_q      <= '0;
            bar_pos_q <= '0;
            bar_idx_q <= '0;
        end else begin
            mode_q    <= mode_d;
            fg_q      <= fg_d;
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Two aligned pipeline stages; reset drives the idle/blank levels immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_de_q  <= 1'b0;
            s1_hs_q  <= ~HSYNC_POL;
            s1_vs_q  <= ~VSYNC_POL;
            s1_fs_q  <= 1'b0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s1_rgb_q <= '0;
            o_de_q   <= 1'b0;
            o_hs_q   <= ~HSYNC_POL;
            o_vs_q   <= ~VSYNC_POL;
            o_fs_q   <= 1'b0;
            o_x_q    <= '0;
            o_y_q    <= '0;
            o_rgb_q  <= '0;
        end else begin
            s1_de_q  <= s1_de_d;
            s1_hs_q  <= s1_hs_d;
            s1_vs_q  <= s1_vs_d;
            s1_fs_q  <= s1_fs_d;
            s1_x_q   <= s1_x_d;
            s1_y_q   <= s1_y_d;
            s1_rgb_q <= s1_rgb_d;
            o_de_q   <= s1_de_q;
            o_hs_q   <= s1_hs_q;
            o_vs_q   <= s1_vs_q;
            o_fs_q   <= s1_fs_q;
            o_x_q    <= s1_x_q;
            o_y_q    <= s1_y_q;
            o_rgb_q  <= s1_rgb_q;
        end
    end

    assign hsync       = o_hs_q;
    assign vsync       = o_vs_q;
    assign de          = o_de_q;
    assign x_addr      = o_x_q;
    assign y_addr      = o_y_q;
    assign red         = o_rgb_q[15:11];
    assign green       = o_rgb_q[10:5];
    assign blue        = o_rgb_q[4:0];
    assign frame_start = o_fs_q;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Scoreboard bench for the VGA timing/pattern generator on a small 24x12 raster.
// Latency: expects pixels 2 clocks behind the internal counters.
// Backpressure: none; monitors sample on the falling clock edge.
module tb_vga_timing_pattern_gen;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [15:0] fg_color;
    logic        hsync, vsync, de, frame_start;
    logic [11:0] x_addr, y_addr;
    logic [4:0]  red, blue;
    logic [5:0]  green;
    logic [15:0] rgb;

    assign rgb = {red, green, blue};

    vga_timing_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .ADDR_W(12), .GRID_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .fg_color(fg_color),
        .hsync(hsync), .vsync(vsync), .de(de),
        .x_addr(x_addr), .y_addr(y_addr),
        .red(red), .green(green), .blue(blue),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [15:0] rgb;
    } pix_t;

    pix_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [1:0]  f_mode [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [15:0] f_fg   [5] = '{16'h1234, 16'hABCD, 16'hF800, 16'h07E0, 16'h001F};

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] exp_rgb(logic [1:0] m, logic [15:0] fg, int x, int y);
        case (m)
            2'd0:    return fg;
            2'd1:    return bars[x / 2];
            2'd2:    return ((x % 4 == 0) || (y % 4 == 0)) ? fg : 16'h0000;
            default: return ((((x / 4) + (y / 4)) % 2) == 0) ? fg : 16'h0000;
        endcase
    endfunction

    task automatic push_frame(logic [1:0] m, logic [15:0] fg);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++)
                sb.push_back('{x: 12'(x), y: 12'(y), rgb: exp_rgb(m, fg, x, y)});
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_hsync"}, hsync, 0);
        check({tag, "_vsync"}, vsync, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_xy"}, {x_addr, y_addr}, 0);
        check({tag, "_rgb"}, rgb, 0);
        check({tag, "_fs"}, frame_start, 0);
    endtask

    task automatic wait_fs();
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (frame_start) found = 1;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_frame_start: got timeout, expected pulse within 400 clocks");
        end
    endtask

    // Pixel monitor: active pixels are popped from the scoreboard, blanking must be all zero.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (de) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_underflow: got pixel x=%0d y=%0d, expected none", x_addr, y_addr);
                    end else begin
                        e = sb.pop_front();
                        check("pixel_xy", {x_addr, y_addr}, {e.x, e.y});
                        check("pixel_rgb", rgb, e.rgb);
                        check("pixel_fs", frame_start, (e.x == 0 && e.y == 0));
                    end
                end else begin
                    check("blank_outputs", {x_addr, y_addr, rgb, frame_start}, 0);
                end
            end
        end
    end

    // Timing monitor: sync placement/width and per-frame totals.
    initial begin
        int cyc, last_de_rise, last_hs_rise, last_fs, hs_w, vs_cnt, de_cnt;
        bit prev_de, prev_hs, fs_seen;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0; last_de_rise = -1000; last_hs_rise = -1000; last_fs = 0;
                hs_w = 0; vs_cnt = 0; de_cnt = 0;
                prev_de = 0; prev_hs = 0; fs_seen = 0;
            end else begin
                cyc++;
                if (frame_start) begin
                    if (fs_seen) begin
                        check("frame_length", cyc - last_fs, 288);
                        check("vsync_clocks", vs_cnt, 48);
                        check("de_clocks", de_cnt, 128);
                    end
                    fs_seen = 1;
                    last_fs = cyc;
                    vs_cnt = 0;
                    de_cnt = 0;
                end
                if (de && !prev_de) last_de_rise = cyc;
                if (hsync && !prev_hs) begin
                    if (cyc - last_de_rise < 24) check("hsync_after_de", cyc - last_de_rise, 18);
                    if (last_hs_rise > 0) check("hsync_period", cyc - last_hs_rise, 24);
                    last_hs_rise = cyc;
                    hs_w = 0;
                end
                if (!hsync && prev_hs) check("hsync_width", hs_w, 3);
                if (hsync) hs_w++;
                if (vsync) vs_cnt++;
                if (de) de_cnt++;
                prev_de = de;
                prev_hs = hsync;
            end
        end
    end

    // Stimulus: directed frame sequence, mid-frame mode switches, then a mid-frame reset.
    initial begin
        bit emptied = 0;
        rst      = 1'b1;
        mode     = f_mode[0];
        fg_color = f_fg[0];
        repeat (3) @(negedge clk);
        check_reset_vals("reset_init");
        push_frame(f_mode[0], f_fg[0]);
        rst = 1'b0;
        @(posedge clk); #1;
        check("fs_edge1", frame_start, 0);
        @(posedge clk); #1;
        check("fs_edge2", {frame_start, de, x_addr, y_addr}, {1'b1, 1'b1, 24'd0});

        for (int f = 1; f < 5; f++) begin
            repeat (100) @(posedge clk);
            @(negedge clk);
            mode     = f_mode[f];
            fg_color = f_fg[f];
            push_frame(f_mode[f], f_fg[f]);
            wait_fs();
        end

        repeat (128) @(posedge clk);
        #1;
        check("pre_reset_pixel", {de, x_addr, y_addr}, {1'b1, 12'd8, 12'd5});
        #1 rst = 1'b1;
        #1;
        check_reset_vals("reset_mid");
        sb.delete();
        push_frame(f_mode[4], f_fg[4]);
        repeat (2) @(negedge clk);
        check_reset_vals("reset_hold");
        rst = 1'b0;
        @(posedge clk); #1;
        check("restart_fs_edge1", frame_start, 0);
        @(posedge clk); #1;
        check("restart_fs_edge2", {frame_start, de, x_addr, y_addr, rgb}, {1'b1, 1'b1, 24'd0, 16'h001F});

        for (int i = 0; i < 400 && !emptied; i++) begin
            @(posedge clk);
            if (sb.size() == 0) emptied = 1;
        end
        check("scoreboard_drained", emptied, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
